xbus_router: RTL and testbench
==============================

// Module: xbus_router
// PURPOSE
//  Registered, parametrised XBUS address router: decodes a master transfer into a one-hot slave select,
//  holds it until the selected slave acks, returns that slave's read data, and answers unmapped
//  addresses or stalled slaves with an error ack. Sits between the core's XBUS master port and the
//  XBUS slaves. Regions are parameters rather than hard-coded windows.
// PARAMETERS
//  NSLAVES   4                       number of slave regions/selects
//  ADDR_W    32                      address width
//  DATA_W    32                      read-data width
//  SLV_BASE  {NSLAVES*ADDR_W}        packed region bases; slice i = slave i
//  SLV_MASK  {NSLAVES*ADDR_W}        packed region masks; all-zero mask = region disabled
//  TIMEOUT   255                     max cycles a select waits for ack; 0 = timeout disabled
//  TO_W      8                       timeout counter width (TIMEOUT < 2**TO_W)
// PORTS
//  clk        in   1                  clock
//  rst        in   1                  synchronous active-high reset
//  xbus_as    in   1                  master address strobe, held high until xbus_ack
//  xbus_addr  in   ADDR_W             master address, stable while xbus_as high
//  xbus_cs    out  NSLAVES            registered one-hot slave select
//  s_ack      in   NSLAVES            per-slave transfer acknowledge
//  s_rdata    in   NSLAVES*DATA_W     per-slave read data, slice i = slave i
//  xbus_ack   out  1                  one-cycle transfer-complete pulse to master
//  xbus_err   out  1                  qualifies xbus_ack: unmapped address or timeout
//  xbus_rdata out  DATA_W             read data, valid with xbus_ack, held until next ack
//  busy       out  1                  high whenever state != IDLE
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high on rst. Reset: state IDLE, xbus_cs=0,
//    xbus_ack=0, xbus_err=0, xbus_rdata=0, busy=0, timeout counter=0. Reset mid-transfer aborts it:
//    no ack is issued.
//  - Hit_i = ((xbus_addr & MASK_i) == BASE_i) && (MASK_i != 0). Overlapping hits: lowest index wins.
//  - FSM: IDLE, ACTIVE, RESP, RELEASE.
//    IDLE: on xbus_as=1 at cycle N: hit -> ACTIVE, xbus_cs=onehot(winner) from N+1.
//          No hit -> RESP with xbus_ack=xbus_err=1 at N+1, xbus_cs stays 0, rdata unchanged.
//    ACTIVE: counter increments each cycle. s_ack[sel]=1 at cycle M -> xbus_cs=0,
//          xbus_ack=1, xbus_err=0, xbus_rdata=s_rdata[sel] at M+1, state RESP.
//          Counter reaches TIMEOUT (TIMEOUT!=0) without ack -> xbus_cs=0, xbus_ack=xbus_err=1
//          next cycle, state RESP, rdata unchanged. Ack on the timeout cycle counts as ack, not error.
//          xbus_as drops (master abort) -> xbus_cs=0 next cycle, IDLE, no ack.
//    RESP: single ack cycle -> RELEASE (IDLE directly if xbus_as already 0).
//    RELEASE: wait for xbus_as=0, then IDLE; back-to-back transfers need one low strobe cycle.
//  - s_ack bits of non-selected slaves are ignored in every state; s_ack in IDLE is ignored.
//  - xbus_ack, xbus_err are single-cycle pulses; xbus_err never high without xbus_ack.
//  - Counter clears on entry to ACTIVE; width TO_W, saturates, never wraps.
//  - At most one xbus_cs bit high at any time; xbus_cs is registered (no combinational addr->cs path).
// STRUCTURE
//  - Package xbus_pkg: state encoding localparams, default map constants
//    (slave0 base 32'h0000_1000 mask 32'hFFFF_FF00; slave1 base 32'h8000_0000 mask 32'hFFFF_0000),
//    default TIMEOUT.
//  - Sub-module xbus_addr_match: combinational parametrised matcher (addr, bases, masks ->
//    one-hot priority winner + any_hit). Router holds FSM, counter, rdata mux/register.
// TESTING
//  - Default map: as=1, addr=32'h0000_1010; slave0 acks 3 cycles after cs, rdata 32'hDEAD_BEEF ->
//    cs=4'b0001 at N+1, ack=1 err=0 rdata=DEAD_BEEF one cycle after s_ack, cs low same cycle.
//  - addr=32'h4000_0000 (unmapped) -> cs never asserts; ack=err=1 at N+1 for exactly one cycle.
//  - TIMEOUT=4, addr=32'h8000_0004, slave1 never acks -> cs=4'b0010 for 4 cycles, then ack=err=1,
//    cs=0; s_ack[0]=1 during wait ignored.
//  - Overlap: slave2 base 32'h8000_0000 mask 32'hF000_0000, addr=32'h8000_0010 -> cs=4'b0010 (lower index).
//  - Abort and reset: drop as mid-ACTIVE -> cs=0 next cycle, no ack; rst mid-ACTIVE -> all outputs 0,
//    busy=0 next cycle.
//  - Back-to-back: as held after ack -> no new cs until as low one cycle; then second transfer completes.

Source files
------------

// File: rtl/xbus_pkg.sv
// rtl/xbus_pkg.sv - shared state encoding and default address map for the XBUS router
package xbus_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACTIVE  = 2'd1;
    localparam logic [1:0] ST_RESP    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_ACTIVE  = ST_ACTIVE,
        S_RESP    = ST_RESP,
        S_RELEASE = ST_RELEASE
    } xbus_state_t;

    // Default geometry
    localparam int XBUS_DEF_NSLAVES = 4;
    localparam int XBUS_DEF_ADDR_W  = 32;
    localparam int XBUS_DEF_DATA_W  = 32;
    localparam int XBUS_DEF_TIMEOUT = 255;
    localparam int XBUS_DEF_TO_W    = 8;

    // Default map: slave0 at 0x0000_10xx, slave1 at 0x8000_xxxx, slaves 2/3 disabled
    localparam logic [XBUS_DEF_NSLAVES*XBUS_DEF_ADDR_W-1:0] XBUS_DEF_BASE = {
        32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 32'h0000_1000
    };
    localparam logic [XBUS_DEF_NSLAVES*XBUS_DEF_ADDR_W-1:0] XBUS_DEF_MASK = {
        32'h0000_0000, 32'h0000_0000, 32'hFFFF_0000, 32'hFFFF_FF00
    };

endpackage

// File: rtl/xbus_addr_match.sv
// rtl/xbus_addr_match.sv - combinational region decoder with lowest-index priority
module xbus_addr_match #(
    parameter int NSLAVES = 4,
    parameter int ADDR_W  = 32
) (
    input  logic [ADDR_W-1:0]         addr,
    input  logic [NSLAVES*ADDR_W-1:0] bases,
    input  logic [NSLAVES*ADDR_W-1:0] masks,
    output logic [NSLAVES-1:0]        winner,
    output logic                      any_hit
);

    logic [NSLAVES-1:0] hits;

    // Raw per-region hits; an all-zero mask disables the region
    always_comb begin
        hits = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            hits[i] = ((addr & masks[i*ADDR_W +: ADDR_W]) == bases[i*ADDR_W +: ADDR_W])
                      && (|masks[i*ADDR_W +: ADDR_W]);
        end
    end

    // Overlapping regions resolve to the lowest index
    always_comb begin
        winner  = '0;
        any_hit = 1'b0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (hits[i] && !any_hit) begin
                winner[i] = 1'b1;
                any_hit   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xbus_router.sv
// rtl/xbus_router.sv - registered XBUS address router with error ack and slave timeout
module xbus_router
    import xbus_pkg::*;
#(
    parameter int                          NSLAVES  = XBUS_DEF_NSLAVES,
    parameter int                          ADDR_W   = XBUS_DEF_ADDR_W,
    parameter int                          DATA_W   = XBUS_DEF_DATA_W,
    parameter logic [NSLAVES*ADDR_W-1:0]   SLV_BASE = XBUS_DEF_BASE,
    parameter logic [NSLAVES*ADDR_W-1:0]   SLV_MASK = XBUS_DEF_MASK,
    parameter int                          TIMEOUT  = XBUS_DEF_TIMEOUT,
    parameter int                          TO_W     = XBUS_DEF_TO_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      xbus_as,
    input  logic [ADDR_W-1:0]         xbus_addr,
    output logic [NSLAVES-1:0]        xbus_cs,
    input  logic [NSLAVES-1:0]        s_ack,
    input  logic [NSLAVES*DATA_W-1:0] s_rdata,
    output logic                      xbus_ack,
    output logic                      xbus_err,
    output logic [DATA_W-1:0]         xbus_rdata,
    output logic                      busy
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

    xbus_state_t        state;
    logic [TO_W-1:0]    wait_cnt;
    logic [TO_W-1:0]    wait_cnt_next;
    logic [NSLAVES-1:0] match_winner;
    logic               match_any;
    logic [DATA_W-1:0]  sel_rdata;
    logic               sel_ack;
    logic               timed_out;

    xbus_addr_match #(
        .NSLAVES (NSLAVES),
        .ADDR_W  (ADDR_W)
    ) u_match (
        .addr    (xbus_addr),
        .bases   (SLV_BASE),
        .masks   (SLV_MASK),
        .winner  (match_winner),
        .any_hit (match_any)
    );

    // Read data and ack of the currently selected slave only; others are ignored
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (xbus_cs[i]) begin
                sel_rdata = sel_rdata | s_rdata[i*DATA_W +: DATA_W];
            end
        end
        sel_ack = |(s_ack & xbus_cs);
    end

    // Saturating wait counter and timeout detection for the current cycle
    always_comb begin
        wait_cnt_next = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
        timed_out     = (TIMEOUT != 0) && (wait_cnt_next >= TO_LIMIT);
    end

    assign busy = (state != S_IDLE);

    // Transfer FSM with registered select, ack/err pulses and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            xbus_cs    <= '0;
            xbus_ack   <= 1'b0;
            xbus_err   <= 1'b0;
            xbus_rdata <= '0;
            wait_cnt   <= '0;
        end else begin
            xbus_ack <= 1'b0;
            xbus_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (xbus_as) begin
                        if (match_any) begin
                            xbus_cs  <= match_winner;
                            wait_cnt <= '0;
                            state    <= S_ACTIVE;
                        end else begin
                            xbus_ack <= 1'b1;
                            xbus_err <= 1'b1;
                            state    <= S_RESP;
                        end
                    end
                end
                S_ACTIVE: begin
                    wait_cnt <= wait_cnt_next;
                    if (!xbus_as) begin
                        // Master abandoned the transfer: release the slave silently
                        xbus_cs <= '0;
                        state   <= S_IDLE;
                    end else if (sel_ack) begin
                        // A real ack beats a timeout landing in the same cycle
                        xbus_cs    <= '0;
                        xbus_ack   <= 1'b1;
                        xbus_rdata <= sel_rdata;
                        state      <= S_RESP;
                    end else if (timed_out) begin
                        xbus_cs  <= '0;
                        xbus_ack <= 1'b1;
                        xbus_err <= 1'b1;
                        state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    state <= xbus_as ? S_RELEASE : S_IDLE;
                end
                S_RELEASE: begin
                    if (!xbus_as) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    xbus_cs <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xbus_router.sv
// tb/tb_xbus_router.sv - directed self-checking bench for xbus_router
module tb_xbus_router;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             xbus_as;
    logic [AW-1:0]    xbus_addr;
    logic [NS-1:0]    xbus_cs;
    logic [NS-1:0]    s_ack;
    logic [NS*DW-1:0] s_rdata;
    logic             xbus_ack;
    logic             xbus_err;
    logic [DW-1:0]    xbus_rdata;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    xbus_router #(
        .NSLAVES  (NS),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .SLV_BASE ({32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_1000}),
        .SLV_MASK ({32'h0000_0000, 32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_FF00}),
        .TIMEOUT  (4),
        .TO_W     (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .xbus_as    (xbus_as),
        .xbus_addr  (xbus_addr),
        .xbus_cs    (xbus_cs),
        .s_ack      (s_ack),
        .s_rdata    (s_rdata),
        .xbus_ack   (xbus_ack),
        .xbus_err   (xbus_err),
        .xbus_rdata (xbus_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the full output set in one go
    task automatic chk_out(input string tag, input logic [3:0] cs, input logic ack,
                           input logic err, input logic [31:0] rdata, input logic bsy);
        chk({tag, ".cs"},    32'(xbus_cs),  32'(cs));
        chk({tag, ".ack"},   32'(xbus_ack), 32'(ack));
        chk({tag, ".err"},   32'(xbus_err), 32'(err));
        chk({tag, ".rdata"}, xbus_rdata,    rdata);
        chk({tag, ".busy"},  32'(busy),     32'(bsy));
    endtask

    initial begin
        rst       = 1'b1;
        xbus_as   = 1'b0;
        xbus_addr = '0;
        s_ack     = '0;
        s_rdata   = '0;
        step();
        step();
        chk_out("reset", 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;

        // s_ack while idle is ignored
        s_ack = 4'b1111;
        step();
        chk_out("idle_ack", 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
        s_ack = '0;

        // Slave0 read, acked 3 cycles after select (coincides with the timeout cycle)
        xbus_as   = 1'b1;
        xbus_addr = 32'h0000_1010;
        s_rdata[0*DW +: DW] = 32'hDEAD_BEEF;
        step();
        chk_out("s0_sel", 4'b0001, 1'b0, 1'b0, 32'h0, 1'b1);
        step();
        step();
        chk_out("s0_wait", 4'b0001, 1'b0, 1'b0, 32'h0, 1'b1);
        step();
        s_ack = 4'b0001;
        step();
        chk_out("s0_ack", 4'b0000, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1);
        s_ack   = '0;
        xbus_as = 1'b0;
        step();
        chk_out("s0_done", 4'b0000, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);

        // Unmapped address: immediate error ack, one cycle only
        xbus_as   = 1'b1;
        xbus_addr = 32'h4000_0000;
        step();
        chk_out("unmap_ack", 4'b0000, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
        step();
        chk_out("unmap_rel", 4'b0000, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1);
        xbus_as = 1'b0;
        step();
        chk("unmap_idle", 32'(busy), 32'd0);

        // Timeout on slave1 with a stray ack from slave0
        xbus_as   = 1'b1;
        xbus_addr = 32'h8000_0004;
        s_ack     = 4'b0001;
        step();
        chk_out("to_sel", 4'b0010, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("to_hold_cs", 32'(xbus_cs), 32'h2);
            chk("to_hold_ack", 32'(xbus_ack), 32'h0);
        end
        step();
        chk_out("to_err", 4'b0000, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
        s_ack   = '0;
        xbus_as = 1'b0;
        step();
        chk_out("to_done", 4'b0000, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);

        // Overlap slave1/slave2: slave1 wins; slave2 ack ignored
        xbus_as   = 1'b1;
        xbus_addr = 32'h8000_0010;
        s_rdata[1*DW +: DW] = 32'h1234_5678;
        s_rdata[2*DW +: DW] = 32'h2222_2222;
        step();
        chk("ovl_sel", 32'(xbus_cs), 32'h2);
        s_ack = 4'b0110;
        step();
        chk_out("ovl_ack", 4'b0000, 1'b1, 1'b0, 32'h1234_5678, 1'b1);
        s_ack   = '0;
        xbus_as = 1'b0;
        step();

        // Address only in slave2's window
        xbus_as   = 1'b1;
        xbus_addr = 32'h8001_0000;
        step();
        chk("s2_sel", 32'(xbus_cs), 32'h4);
        s_ack = 4'b0100;
        step();
        chk_out("s2_ack", 4'b0000, 1'b1, 1'b0, 32'h2222_2222, 1'b1);
        s_ack   = '0;
        xbus_as = 1'b0;
        step();

        // Master abort mid-transfer
        xbus_as   = 1'b1;
        xbus_addr = 32'h0000_1020;
        step();
        chk("abort_sel", 32'(xbus_cs), 32'h1);
        xbus_as = 1'b0;
        step();
        chk_out("abort", 4'b0000, 1'b0, 1'b0, 32'h2222_2222, 1'b0);
        step();
        chk("abort_noack", 32'(xbus_ack), 32'h0);

        // Reset mid-transfer
        xbus_as = 1'b1;
        step();
        chk("rst_sel", 32'(xbus_cs), 32'h1);
        rst = 1'b1;
        step();
        chk_out("rst_mid", 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
        rst     = 1'b0;
        xbus_as = 1'b0;
        step();

        // Back-to-back: strobe held after ack blocks a new select until it drops
        xbus_as = 1'b1;
        s_rdata[0*DW +: DW] = 32'hCAFE_0001;
        step();
        s_ack = 4'b0001;
        step();
        chk_out("b2b_ack1", 4'b0000, 1'b1, 1'b0, 32'hCAFE_0001, 1'b1);
        s_ack = '0;
        step();
        chk_out("b2b_rel", 4'b0000, 1'b0, 1'b0, 32'hCAFE_0001, 1'b1);
        step();
        chk_out("b2b_hold", 4'b0000, 1'b0, 1'b0, 32'hCAFE_0001, 1'b1);
        xbus_as = 1'b0;
        step();
        chk("b2b_idle", 32'(busy), 32'h0);
        xbus_as = 1'b1;
        s_rdata[0*DW +: DW] = 32'hCAFE_0002;
        step();
        chk("b2b_sel2", 32'(xbus_cs), 32'h1);
        s_ack = 4'b0001;
        step();
        chk_out("b2b_ack2", 4'b0000, 1'b1, 1'b0, 32'hCAFE_0002, 1'b1);
        s_ack   = '0;
        xbus_as = 1'b0;
        step();
        chk_out("b2b_end", 4'b0000, 1'b0, 1'b0, 32'hCAFE_0002, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
